// File: rtl/regfile_wport_arbiter.sv
// Shares the single register-file write port between WB, the $k0 save slot and a UART byte FIFO.
// Latency: rf_* is a zero-latency mux; buffered writes drain on the first cycle WB leaves the port idle.
// Backpressure: uart_ready drops while the byte FIFO is full; WB is never stalled.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdat,
  output logic [WIDTH-1:0] rdat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty when the indices match
  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdat;
  end

  assign rdat  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

module regfile_wport_arbiter #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [4:0] K0_ADDR    = 5'd26,
  parameter logic [4:0] UART_REG1  = 5'd4,
  parameter logic [4:0] UART_REG2  = 5'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        exc_req,
  input  logic [31:0] exc_data,
  input  logic        uart_valid,
  input  logic [7:0]  uart_byte,
  output logic        uart_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        exc_pending,
  output logic        exc_overrun,
  output logic        pair_done
);
  logic        wb_act, exc_win, fifo_win;
  logic        fifo_full, fifo_empty, fifo_push;
  logic [12:0] fifo_head, fifo_wdat;
  logic        pair_flag;
  logic [31:0] exc_dat_q;

  // A WB write to $0 is a no-op and leaves the port free for buffered writes
  assign wb_act   = wb_we && (wb_addr != 5'd0);
  assign exc_win  = !wb_act && exc_pending;
  assign fifo_win = !wb_act && !exc_pending && !fifo_empty;

  assign uart_ready = !fifo_full;
  assign fifo_push  = uart_valid && !fifo_full;
  assign fifo_wdat  = {uart_byte, pair_flag ? UART_REG2 : UART_REG1};

  sync_fifo #(.WIDTH(13), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_win),
    .wdat  (fifo_wdat),
    .rdat  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (wb_act) begin
      rf_we   = 1'b1;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (exc_pending) begin
      rf_we   = 1'b1;
      rf_addr = K0_ADDR;
      rf_data = exc_dat_q;
    end else if (!fifo_empty) begin
      rf_we   = 1'b1;
      rf_addr = fifo_head[4:0];
      rf_data = {24'd0, fifo_head[12:5]};
    end
    // WB inputs are not reset, so the enable is masked directly during reset
    rf_we = rf_we && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_pending <= 1'b0;
      exc_overrun <= 1'b0;
      exc_dat_q   <= 32'd0;
      pair_flag   <= 1'b0;
      pair_done   <= 1'b0;
    end else begin
      exc_overrun <= 1'b0;
      if (exc_req) begin
        exc_dat_q   <= exc_data;
        exc_pending <= 1'b1;
        // Overrun only when the old value is lost, not when it drains this cycle
        exc_overrun <= exc_pending && !exc_win;
      end else if (exc_win) begin
        exc_pending <= 1'b0;
      end
      if (fifo_push) pair_flag <= !pair_flag;
      pair_done <= fifo_win && (fifo_head[4:0] == UART_REG2);
    end
  end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: queue-based reference model checked every cycle
// plus literal expectations for each scenario.
module tb_regfile_wport_arbiter;
  logic        clk, rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exc_req;
  logic [31:0] exc_data;
  logic        uart_valid;
  logic [7:0]  uart_byte;
  logic        uart_ready, rf_we, exc_pending, exc_overrun, pair_done;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_wport_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exc_req(exc_req), .exc_data(exc_data),
    .uart_valid(uart_valid), .uart_byte(uart_byte), .uart_ready(uart_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .exc_pending(exc_pending), .exc_overrun(exc_overrun), .pair_done(pair_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue with destination tags, one save slot, pair toggle
  typedef struct {
    logic [7:0] b;
    logic [4:0] tag;
  } ent_t;
  ent_t        q[$];
  bit          m_pend;
  logic [31:0] m_pdat;
  bit          m_flag, m_ovr, m_pd;

  always @(negedge clk) begin
    bit          e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          src;
    bit          can_push;
    ent_t        e;
    if (!rst_n) begin
      q.delete();
      m_pend = 0; m_flag = 0; m_ovr = 0; m_pd = 0;
      chk("m_rst_rf_we", rf_we, 0);
      chk("m_rst_ready", uart_ready, 1);
      chk("m_rst_pending", exc_pending, 0);
      chk("m_rst_overrun", exc_overrun, 0);
      chk("m_rst_pair_done", pair_done, 0);
    end else begin
      src = 0; e_we = 0; e_addr = 0; e_data = 0;
      if (wb_we && wb_addr != 0) begin
        src = 1; e_we = 1; e_addr = wb_addr; e_data = wb_data;
      end else if (m_pend) begin
        src = 2; e_we = 1; e_addr = 5'd26; e_data = m_pdat;
      end else if (q.size() > 0) begin
        src = 3; e_we = 1; e_addr = q[0].tag; e_data = {24'd0, q[0].b};
      end
      chk("m_rf_we", rf_we, e_we);
      if (e_we) begin
        chk("m_rf_addr", rf_addr, e_addr);
        chk("m_rf_data", rf_data, e_data);
      end
      if (rf_we) chk("m_no_reg0", rf_addr == 5'd0, 0);
      chk("m_uart_ready", uart_ready, q.size() < 4);
      chk("m_exc_pending", exc_pending, m_pend);
      chk("m_exc_overrun", exc_overrun, m_ovr);
      chk("m_pair_done", pair_done, m_pd);
      // advance to the state after the coming edge
      can_push = q.size() < 4;
      m_pd = 0;
      if (src == 3) begin
        m_pd = (q[0].tag == 5'd5);
        void'(q.pop_front());
      end
      if (uart_valid && can_push) begin
        e.b = uart_byte;
        e.tag = m_flag ? 5'd5 : 5'd4;
        q.push_back(e);
        m_flag = !m_flag;
      end
      m_ovr = 0;
      if (exc_req) begin
        m_ovr = m_pend && (src != 2);
        m_pend = 1;
        m_pdat = exc_data;
      end else if (src == 2) begin
        m_pend = 0;
      end
    end
  end

  task automatic smp(); @(negedge clk); endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  task automatic idle_inputs();
    wb_we = 0; wb_addr = 0; wb_data = 0;
    exc_req = 0; exc_data = 0;
    uart_valid = 0; uart_byte = 0;
  endtask

  initial begin
    logic [4:0]  rec_a[$];
    logic [31:0] rec_d[$];
    int          idx;
    int          ovr_cnt;
    logic [4:0]  exp_a [5];
    exp_a[0] = 5'd4; exp_a[1] = 5'd5; exp_a[2] = 5'd4; exp_a[3] = 5'd5; exp_a[4] = 5'd4;

    // Reset with WB asserted: the enable must stay low
    idle_inputs();
    rst_n = 0;
    wb_we = 1; wb_addr = 5'd3; wb_data = 32'h1;
    smp();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_uart_ready", uart_ready, 1);
    chk("rst_exc_pending", exc_pending, 0);
    nxt();
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("idle_rf_we", rf_we, 0);
      nxt();
    end

    // WB and exception in the same cycle
    wb_we = 1; wb_addr = 5'd8; wb_data = 32'hDEADBEEF;
    exc_req = 1; exc_data = 32'h00400010;
    smp();
    chk("wb_rf_we", rf_we, 1);
    chk("wb_rf_addr", rf_addr, 8);
    chk("wb_rf_data", rf_data, 32'hDEADBEEF);
    nxt();
    idle_inputs();
    smp();
    chk("k0_pending", exc_pending, 1);
    chk("k0_rf_addr", rf_addr, 26);
    chk("k0_rf_data", rf_data, 32'h00400010);
    nxt();
    smp();
    chk("k0_cleared", exc_pending, 0);
    chk("k0_then_idle", rf_we, 0);
    nxt();

    // UART pair with WB idle
    uart_valid = 1; uart_byte = 8'h12;
    smp();
    nxt();
    uart_byte = 8'h34;
    smp();
    chk("pair1_addr", rf_addr, 4);
    chk("pair1_data", rf_data, 32'h12);
    nxt();
    uart_valid = 0;
    smp();
    chk("pair2_addr", rf_addr, 5);
    chk("pair2_data", rf_data, 32'h34);
    chk("pair2_no_done_yet", pair_done, 0);
    nxt();
    smp();
    chk("pair_done_pulse", pair_done, 1);
    nxt();
    smp();
    chk("pair_done_single", pair_done, 0);
    nxt();

    // FIFO fills behind a busy WB, then drains in order
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      wb_we = (c < 8); wb_addr = 5'd9; wb_data = 32'h99;
      uart_valid = (idx < 5); uart_byte = 8'hA0 + 8'(idx);
      smp();
      if (c == 5) begin
        chk("full_ready_low", uart_ready, 0);
        chk("full_accepts", idx, 4);
      end
      if (!wb_we && rf_we) begin
        rec_a.push_back(rf_addr);
        rec_d.push_back(rf_data);
      end
      if (uart_valid && uart_ready) idx++;
      nxt();
    end
    idle_inputs();
    chk("drain_count", rec_a.size(), 5);
    for (int i = 0; i < 5 && i < rec_a.size(); i++) begin
      chk("drain_addr", rec_a[i], exp_a[i]);
      chk("drain_data", rec_d[i], 32'hA0 + i);
    end

    // Overrun: two saves behind a busy WB, only the second survives
    ovr_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      wb_we = 1; wb_addr = 5'd10; wb_data = 32'h10;
      exc_req = (c < 2); exc_data = (c == 0) ? 32'h111 : 32'h222;
      smp();
      if (exc_overrun) ovr_cnt++;
      nxt();
    end
    idle_inputs();
    smp();
    chk("overrun_count", ovr_cnt, 1);
    chk("overrun_k0_addr", rf_addr, 26);
    chk("overrun_k0_data", rf_data, 32'h222);
    nxt();
    smp();
    chk("overrun_drained", rf_we, 0);
    nxt();

    // WB to $0 yields the port; drain plus new request gives no overrun
    wb_we = 1; wb_addr = 5'd12; wb_data = 32'h12;
    exc_req = 1; exc_data = 32'h333;
    smp();
    nxt();
    wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    exc_data = 32'h444;
    smp();
    chk("wb0_rf_we", rf_we, 1);
    chk("wb0_rf_addr", rf_addr, 26);
    chk("wb0_rf_data", rf_data, 32'h333);
    nxt();
    idle_inputs();
    smp();
    chk("drain_req_no_overrun", exc_overrun, 0);
    chk("drain_req_pending", exc_pending, 1);
    chk("drain_req_data", rf_data, 32'h444);
    nxt();

    // Reset mid-operation discards the buffered byte and restarts pairing
    wb_we = 1; wb_addr = 5'd13; wb_data = 32'h13;
    uart_valid = 1; uart_byte = 8'h55;
    smp();
    nxt();
    uart_valid = 0;
    rst_n = 0;
    smp();
    chk("midrst_rf_we", rf_we, 0);
    chk("midrst_ready", uart_ready, 1);
    nxt();
    rst_n = 1;
    wb_we = 0;
    uart_valid = 1; uart_byte = 8'h66;
    smp();
    chk("postrst_empty", rf_we, 0);
    nxt();
    uart_valid = 0;
    smp();
    chk("postrst_addr", rf_addr, 4);
    chk("postrst_data", rf_data, 32'h66);
    nxt();
    for (int i = 0; i < 3; i++) begin
      smp();
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
Owns the single register-file write port and shares it between three requesters: pipeline write-back (WB), the exception/interrupt return-address save into $k0, and UART operand bytes. WB is never delayed; the other two are buffered and drained into idle write cycles. The block sits between the WB stage, the ID-stage interrupt/exception logic, the UART receiver and the RegisterFile write port, and replaces the file's private UART and $k0 write paths.

Parameters:
FIFO_DEPTH, 4, UART byte FIFO entries; power of two, at least 2
K0_ADDR, 5'd26, register written by exception/interrupt save
UART_REG1, 5'd4, destination of first byte of each UART pair
UART_REG2, 5'd5, destination of second byte of each UART pair

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
wb_we  in  1  WB write request
wb_addr  in  5  WB destination register
wb_data  in  32  WB write data
exc_req  in  1  one-cycle pulse: save exc_data into $k0
exc_data  in  32  return address to save
uart_valid  in  1  UART byte available
uart_byte  in  8  UART received byte
uart_ready  out  1  FIFO can accept a byte this cycle
rf_we  out  1  register-file write enable
rf_addr  out  5  register-file write address
rf_data  out  32  register-file write data
exc_pending  out  1  $k0 save latched, not yet written
exc_overrun  out  1  one-cycle pulse: pending save overwritten
pair_done  out  1  one-cycle pulse: UART_REG2 byte committed

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n); polarity and synchronicity are fixed.
- Reset clears FIFO (empty), pending slot, pair flag (0) and all registered outputs: uart_ready=1, exc_pending=0, exc_overrun=0, pair_done=0. rf_we=0 while rst_n=0.
- rf_* is combinational: zero-latency mux from current WB inputs and registered internal state.
- Priority, evaluated each cycle:
  - WB, when wb_we=1 and wb_addr!=0: rf_* = WB inputs.
  - Pending $k0 save: rf_* = {K0_ADDR, saved data}.
  - FIFO head: rf_addr = tagged addr, rf_data = {24'b0, byte}.
  - Otherwise rf_we=0.
- A WB write to $0 counts as idle: rf_we=0, and the cycle is available to lower priorities.
- Exception slot:
  - exc_req=1 latches exc_data at the next edge and sets exc_pending.
  - The slot is written in the first cycle it wins arbitration and clears at that edge.
  - exc_req=1 while pending: the new data overwrites, exc_overrun pulses 1 cycle, exc_pending stays 1.
  - exc_req in the same cycle the old slot drains: the old value is written, the new one latched, no overrun.
- UART FIFO:
  - Accept when uart_valid=1 and uart_ready=1. uart_ready = ~full.
  - Each entry stores {byte, tag}. The tag is UART_REG1 if the pair flag is 0, else UART_REG2. The flag toggles on every accept.
  - The head pops at the edge of a cycle in which it wins the port.
  - Push and pop in the same cycle are both allowed; when full, uart_ready=0 blocks the push.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - pair_done pulses on the edge after a UART_REG2-tagged entry is written.
- Ordering: a same-register WB issued after a buffered UART/$k0 write is not protected; the later-drained buffered write wins. Software owns this.
- Starvation: continuous WB writes stall the exception and UART drains indefinitely. This is accepted.
- Reset mid-operation discards pending and FIFO contents; the next UART byte after reset goes to UART_REG1.

Test Plan:
- Reset, then idle: rf_we=0, uart_ready=1, exc_pending=0; after releasing rst_n, no spurious writes for 10 cycles.
- wb_we=1, wb_addr=8, wb_data=32'hDEADBEEF with exc_req=1, exc_data=32'h00400010 in the same cycle -> same cycle rf={8,DEADBEEF}. Next cycle (wb_we=0) rf={26,00400010}, and exc_pending falls after that edge.
- Bytes 8'h12 then 8'h34 with WB idle -> rf={4,32'h12} then {5,32'h34}; pair_done pulses once after the second write.
- wb_we=1 to register 9 for 8 cycles while 5 UART bytes arrive -> uart_ready drops after 4 accepts. After WB stops, the bytes drain in order to regs 4,5,4,5, then the 5th byte goes to reg 4.
- exc_req twice (data A, then B) with WB busy -> exc_overrun pulses once; on drain only B is written to $k0.
- wb_we=1, wb_addr=0 with a pending $k0 save -> rf_we=1 to reg 26 that cycle; register 0 is never written.
